mips_mc_control: RTL and testbench

- Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational decoder with an FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects and enables.
- Waits on a shared instruction/data memory through a ready handshake.
- Traps on illegal opcodes and on memory timeouts.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_mem_watchdog.sv | 30 +++
 rtl/mips_mc_control.sv | 195 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, multi-cycle control states and the
// mux/ALU/trap encodings used across the datapath and control blocks.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REGB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_TIMEOUT = 2'd2;

endpackage

// File: rtl/mips_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags the
// stall cycle that reaches TIMEOUT (TIMEOUT=0 disables it).
module mips_mem_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    // expired fires combinationally on the TIMEOUT-th stall cycle, so the
    // count only has to reach TIMEOUT-1 in the register.
    localparam logic [TMO_W-1:0] LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (waiting) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && waiting && (count == LAST);

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, handshakes with shared memory, traps on bad opcodes/timeouts.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    state_t     state, state_next;
    logic [1:0] cause_next;
    logic [1:0] trap_cause_q;
    logic       waiting, expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            trap_cause_q <= TC_NONE;
        end else begin
            state <= state_next;
            if (state != S_TRAP && state_next == S_TRAP) begin
                trap_cause_q <= cause_next;
            end
        end
    end

    assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                     && !mem_ready;

    mips_mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .clear   (state_next != state),
        .expired (expired)
    );

    // alu_zero is consumed by the datapath through pc_write_cond; the
    // sequence itself never branches on it.
    logic unused_zero;
    assign unused_zero = alu_zero;

    always_comb begin
        state_next    = state;
        cause_next    = TC_NONE;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_ADD;
        pc_src        = PC_ALU;
        retire        = 1'b0;
        trap          = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (expired) begin
                    state_next = S_TRAP;
                    cause_next = TC_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = TC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (expired) begin
                    state_next = S_TRAP;
                    cause_next = TC_TIMEOUT;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (expired) begin
                    state_next = S_TRAP;
                    cause_next = TC_TIMEOUT;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_src        = PC_ALUOUT;
                pc_write_cond = 1'b1;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = S_TRAP;
                cause_next = TC_ILLEGAL;
            end
        endcase
    end

    assign trap_cause = trap_cause_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: walks instruction sequences with
// random memory latency and checks every cycle against a per-phase table.
module tb_mips_mc_control;
    import mips_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, trap;
    logic [1:0] alu_src_b, alu_op, pc_src, trap_cause;
    logic [3:0] state_dbg;

    mips_mc_control #(
        .TIMEOUT (TMO),
        .TMO_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .retire        (retire),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    logic [19:0] dut_ctrl;
    assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_src, retire, trap, trap_cause};

    int n_cmp = 0;
    int n_err = 0;
    int trap_hold = 3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for each documented phase, same packing as dut_ctrl.
    function automatic logic [19:0] exp_ctrl(input int ph, input bit rdy, input logic [1:0] cause);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, asa = 0, ret = 0, trp = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0, tc = 0;
        case (ph)
            0:  begin mrd = 1; asb = 1; irw = rdy; pw = rdy; end
            1:  asb = 3;
            2:  begin asa = 1; asb = 2; end
            3:  begin io = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin io = 1; mwr = 1; ret = rdy; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rd = 1; rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 1; psrc = 1; pwc = 1; ret = 1; end
            9:  begin asa = 1; asb = 2; end
            10: begin rw = 1; ret = 1; end
            11: begin psrc = 2; pw = 1; ret = 1; end
            15: begin trp = 1; tc = cause; end
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ret, trp, tc};
    endfunction

    task automatic cycle(input int ph, input bit rdy, input logic [5:0] op, input logic [1:0] cause);
        mem_ready = rdy;
        opcode    = op;
        alu_zero  = 1'($urandom);
        @(negedge clk);
        check_eq($sformatf("state_ph%0d", ph), 32'(state_dbg), 32'(ph));
        check_eq($sformatf("ctrl_ph%0d_rdy%0d", ph, rdy), 32'(dut_ctrl), 32'(exp_ctrl(ph, rdy, cause)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // A memory phase stalls wait_n cycles; the TMO-th stall ends in a trap.
    task automatic mem_phase(input int ph, input logic [5:0] op, input int wait_n, output bit timed_out);
        timed_out = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
            cycle(ph, 1'b0, op, TC_NONE);
            if (k + 1 == TMO) begin
                timed_out = 1'b1;
                return;
            end
        end
        cycle(ph, 1'b1, op, TC_NONE);
    endtask

    task automatic trap_out(input logic [1:0] cause);
        for (int i = 0; i < trap_hold; i++) begin
            cycle(15, 1'($urandom), 6'($urandom), cause);
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit to;
        mem_phase(0, 6'($urandom), wf, to);
        if (to) begin
            trap_out(TC_TIMEOUT);
            return;
        end
        cycle(1, 1'($urandom), op, TC_NONE);
        case (op)
            OP_LW: begin
                cycle(2, 1'($urandom), op, TC_NONE);
                mem_phase(3, op, wm, to);
                if (to) trap_out(TC_TIMEOUT);
                else cycle(4, 1'($urandom), op, TC_NONE);
            end
            OP_SW: begin
                cycle(2, 1'($urandom), op, TC_NONE);
                mem_phase(5, op, wm, to);
                if (to) trap_out(TC_TIMEOUT);
            end
            OP_RTYPE: begin
                cycle(6, 1'($urandom), op, TC_NONE);
                cycle(7, 1'($urandom), op, TC_NONE);
            end
            OP_BEQ: cycle(8, 1'($urandom), op, TC_NONE);
            OP_ADDI: begin
                cycle(9, 1'($urandom), op, TC_NONE);
                cycle(10, 1'($urandom), op, TC_NONE);
            end
            OP_J: cycle(11, 1'($urandom), op, TC_NONE);
            default: trap_out(TC_ILLEGAL);
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] legal [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
        logic [5:0] o;
        if ($urandom_range(0, 9) != 0) return legal[$urandom_range(0, 5)];
        do o = 6'($urandom);
        while (o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ || o == OP_ADDI || o == OP_J);
        return o;
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
    endfunction

    initial begin
        bit to;
        rst       = 1'b1;
        opcode    = '0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then a fetch held off for three cycles.
        mem_phase(0, OP_RTYPE, 3, to);
        cycle(1, 1'b1, OP_RTYPE, TC_NONE);
        cycle(6, 1'b1, OP_RTYPE, TC_NONE);
        cycle(7, 1'b1, OP_RTYPE, TC_NONE);

        // Reset while a load is stalled in MEMRD.
        cycle(0, 1'b1, OP_LW, TC_NONE);
        cycle(1, 1'b1, OP_LW, TC_NONE);
        cycle(2, 1'b1, OP_LW, TC_NONE);
        cycle(3, 1'b0, OP_LW, TC_NONE);
        rst = 1'b1;
        cycle(3, 1'b0, OP_LW, TC_NONE);
        rst = 1'b0;
        cycle(0, 1'b0, OP_LW, TC_NONE);
        do_reset();

        run_instr(OP_LW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_SW, 0, TMO);
        run_instr(OP_SW, 0, TMO - 1);
        run_instr(OP_LW, 1, TMO);
        trap_hold = 20;
        run_instr(6'h3F, 0, 0);
        trap_hold = 3;
        run_instr(OP_J, 0, 0);

        for (int n = 0; n < 400; n++) begin
            run_instr(pick_op(), pick_wait(), pick_wait());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
